// File: rtl/picorv32_write_buffer_if.sv
// PicoRV32 native memory port bundle.
// master: drives the request (valid, instr, addr, wdata, wstrb) and receives ready/rdata.
// slave:  receives the request and returns ready/rdata.
interface picorv32_write_buffer_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/picorv32_write_buffer.sv
// Posted-write buffer between the PicoRV32 native memory port and the FreeAHB adapter.
// Writes are acknowledged one cycle after they are seen and queued in a DEPTH-entry FIFO that
// drains in order to the downstream port. Reads wait until the FIFO is empty and the downstream
// side is idle, then pass through, so read-after-write ordering holds.
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   up          - slave side, connected to the core
//   dn          - master side, connected to the adapter
//   wbuf_count  - entries currently queued (0..DEPTH)
//   wbuf_empty  - no entries queued and no write in flight downstream
// All outputs are registered.
module picorv32_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    picorv32_write_buffer_if.slave         up,
    picorv32_write_buffer_if.master        dn,
    output logic [4:0]                     wbuf_count,
    output logic                           wbuf_empty
);

    localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DepthCnt = 5'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

    // FIFO storage
    logic [31:0] fifo_addr  [DEPTH];
    logic [31:0] fifo_wdata [DEPTH];
    logic [3:0]  fifo_wstrb [DEPTH];

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [4:0]      count_q;
    logic [4:0]      count_d;
    logic            empty_q;

    state_e          state_q;
    logic            up_ready_q;
    logic [31:0]     up_rdata_q;
    logic            dn_valid_q;
    logic            dn_instr_q;
    logic [31:0]     dn_addr_q;
    logic [31:0]     dn_wdata_q;
    logic [3:0]      dn_wstrb_q;

    logic push;
    logic pop;
    logic rd_req;

    // Full is judged on the pre-edge count, so a full FIFO never pushes and pops together.
    assign push   = up.mem_valid && (up.mem_wstrb != 4'b0000) && !up_ready_q
                    && (count_q < DepthCnt);
    assign rd_req = up.mem_valid && (up.mem_wstrb == 4'b0000) && !up_ready_q;
    assign pop    = (state_q == StWr) && dn.mem_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (!push && pop) begin
            count_d = count_q - 5'd1;
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q]  <= up.mem_addr;
            fifo_wdata[wr_ptr_q] <= up.mem_wdata;
            fifo_wstrb[wr_ptr_q] <= up.mem_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            empty_q    <= 1'b1;
            state_q    <= StIdle;
            up_ready_q <= 1'b0;
            up_rdata_q <= 32'h0;
            dn_valid_q <= 1'b0;
            dn_instr_q <= 1'b0;
            dn_addr_q  <= 32'h0;
            dn_wdata_q <= 32'h0;
            dn_wstrb_q <= 4'h0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // A write in flight always still occupies its FIFO slot until it pops, so an empty
            // FIFO after this edge also means nothing is being written downstream.
            empty_q <= (count_d == 5'd0);

            // Write ack; the RD state overrides this with the read completion pulse.
            up_ready_q <= push;

            unique case (state_q)
                StIdle: begin
                    if (count_q != 5'd0) begin
                        dn_addr_q  <= fifo_addr[rd_ptr_q];
                        dn_wdata_q <= fifo_wdata[rd_ptr_q];
                        dn_wstrb_q <= fifo_wstrb[rd_ptr_q];
                        dn_instr_q <= 1'b0;
                        dn_valid_q <= 1'b1;
                        state_q    <= StWr;
                    end else if (push) begin
                        // FIFO empty: the entry being pushed is the head, so forward it in the
                        // same edge to start the drain one cycle after the accept.
                        dn_addr_q  <= up.mem_addr;
                        dn_wdata_q <= up.mem_wdata;
                        dn_wstrb_q <= up.mem_wstrb;
                        dn_instr_q <= 1'b0;
                        dn_valid_q <= 1'b1;
                        state_q    <= StWr;
                    end else if (rd_req) begin
                        dn_addr_q  <= up.mem_addr;
                        dn_instr_q <= up.mem_instr;
                        dn_wstrb_q <= 4'h0;
                        dn_valid_q <= 1'b1;
                        state_q    <= StRd;
                    end
                end
                StWr: begin
                    if (dn.mem_ready) begin
                        dn_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StRd: begin
                    if (dn.mem_ready) begin
                        up_rdata_q <= dn.mem_rdata;
                        up_ready_q <= 1'b1;
                        dn_valid_q <= 1'b0;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign up.mem_ready = up_ready_q;
    assign up.mem_rdata = up_rdata_q;
    assign dn.mem_valid = dn_valid_q;
    assign dn.mem_instr = dn_instr_q;
    assign dn.mem_addr  = dn_addr_q;
    assign dn.mem_wdata = dn_wdata_q;
    assign dn.mem_wstrb = dn_wstrb_q;
    assign wbuf_count   = count_q;
    assign wbuf_empty   = empty_q;

endmodule
